// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: holds the fetch PC and picks the next one from
// sequential, branch target, jump target or hold. Each taken redirect
// starts a timed flush of younger instructions and bumps a saturating
// redirect counter.
module fetch_pc_ctrl #(
  parameter int                    PC_WIDTH     = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
  parameter int                    INSTR_BYTES  = 2,
  parameter int                    FLUSH_CYCLES = 1,
  parameter int                    CNT_WIDTH    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 brchValid,
  input  logic                 jmpSel,
  input  logic [PC_WIDTH-1:0]  brchTgt,
  input  logic                 jmpValid,
  input  logic [PC_WIDTH-1:0]  jmpTgt,
  input  logic                 haltReq,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  pcPlus,
  output logic                 fetchValid,
  output logic                 flush,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] redirCnt
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALTED} state_t;

  // Flush length is limited to 1..7, so three bits hold the bubble count.
  localparam logic [2:0]          FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [PC_WIDTH-1:0] PC_INC     = PC_WIDTH'(INSTR_BYTES);

  state_t                state_reg, state_next;
  logic [PC_WIDTH-1:0]   pc_reg, pc_next;
  logic [2:0]            fcnt_reg, fcnt_next;
  logic [CNT_WIDTH-1:0]  rcnt_reg, rcnt_next;

  logic                  redirect;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc_plus_w;
  logic [CNT_WIDTH-1:0]  rcnt_sat;

  // A jump always wins over a taken conditional branch.
  assign redirect  = jmpValid | (brchValid & jmpSel);
  assign target    = jmpValid ? jmpTgt : brchTgt;
  assign pc_plus_w = pc_reg + PC_INC;
  assign rcnt_sat  = (rcnt_reg == '1) ? rcnt_reg : rcnt_reg + CNT_WIDTH'(1);

  // State, PC, flush counter and redirect counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_PC;
      fcnt_reg  <= '0;
      rcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      fcnt_reg  <= fcnt_next;
      rcnt_reg  <= rcnt_next;
    end
  end

  // Next-state selection: halt beats redirect beats stall beats sequential.
  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    fcnt_next  = fcnt_reg;
    rcnt_next  = rcnt_reg;
    case (state_reg)
      BOOT: state_next = RUN;
      RUN, FLUSH: begin
        if (haltReq) begin
          state_next = HALTED;
          fcnt_next  = '0;
        end else if (redirect) begin
          // Stall never blocks a redirect; a redirect in FLUSH restarts it.
          pc_next    = target;
          fcnt_next  = FLUSH_LOAD;
          state_next = FLUSH;
          rcnt_next  = rcnt_sat;
        end else if (state_reg == FLUSH) begin
          // PC parks on the target while the bubbles drain.
          fcnt_next = fcnt_reg - 3'd1;
          if (fcnt_reg == 3'd1) begin
            state_next = RUN;
          end
        end else if (!stall) begin
          pc_next = pc_plus_w;
        end
      end
      HALTED: state_next = HALTED;
      default: state_next = BOOT;
    endcase
  end

  assign pc         = pc_reg;
  assign pcPlus     = pc_plus_w;
  assign fetchValid = (state_reg == RUN) & ~stall;
  assign flush      = (state_reg == FLUSH);
  assign halted     = (state_reg == HALTED);
  assign redirCnt   = rcnt_reg;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Bench for fetch_pc_ctrl: two instances (1 and 3 flush cycles) share the
// same stimulus and are compared against a behavioural model, a directed
// vector table, and hand-written multi-cycle sequences.
module tb_fetch_pc_ctrl;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        js;
    logic [15:0] bt;
    logic        jv;
    logic [15:0] jt;
    logic        halt;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [15:0] pc;
    logic        fv;
    logic        fl;
    logic [7:0]  cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, brchValid = 1'b0, jmpSel = 1'b0, jmpValid = 1'b0, haltReq = 1'b0;
  logic [15:0] brchTgt = '0, jmpTgt = '0;

  logic [15:0] pc_w [2];
  logic [15:0] pcp_w [2];
  logic        fv_w [2];
  logic        fl_w [2];
  logic        hl_w [2];
  logic [7:0]  cnt_w [2];

  int checks = 0;
  int failures = 0;

  // Behavioural model state, one slot per instance.
  int m_flen [2] = '{1, 3};
  bit m_boot [2];
  bit m_halted [2];
  int m_flush_left [2];
  int m_pc [2];
  int m_cnt [2];

  always #5 clk = ~clk;

  fetch_pc_ctrl #(.FLUSH_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .brchValid(brchValid), .jmpSel(jmpSel),
    .brchTgt(brchTgt), .jmpValid(jmpValid), .jmpTgt(jmpTgt), .haltReq(haltReq),
    .pc(pc_w[0]), .pcPlus(pcp_w[0]), .fetchValid(fv_w[0]), .flush(fl_w[0]),
    .halted(hl_w[0]), .redirCnt(cnt_w[0])
  );

  fetch_pc_ctrl #(.FLUSH_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .brchValid(brchValid), .jmpSel(jmpSel),
    .brchTgt(brchTgt), .jmpValid(jmpValid), .jmpTgt(jmpTgt), .haltReq(haltReq),
    .pc(pc_w[1]), .pcPlus(pcp_w[1]), .fetchValid(fv_w[1]), .flush(fl_w[1]),
    .halted(hl_w[1]), .redirCnt(cnt_w[1])
  );

  function automatic stim_t mk(input logic st, input logic bv, input logic js, input logic [15:0] bt,
                               input logic jv, input logic [15:0] jt, input logic halt);
    stim_t s;
    s.stall = st; s.bv = bv; s.js = js; s.bt = bt; s.jv = jv; s.jt = jt; s.halt = halt;
    return s;
  endfunction

  function automatic vec_t mv(input stim_t s, input logic [15:0] pc, input logic fv,
                              input logic fl, input logic [7:0] cnt);
    vec_t v;
    v.s = s; v.pc = pc; v.fv = fv; v.fl = fl; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_boot[d] = 1; m_halted[d] = 0; m_flush_left[d] = 0; m_pc[d] = 0; m_cnt[d] = 0;
    end
  endtask

  // One clock of the sequencer rules, written in terms of "cycles left to flush".
  task automatic model_step(input stim_t s);
    bit taken;
    int tgt;
    taken = s.jv || (s.bv && s.js);
    tgt   = s.jv ? int'(s.jt) : int'(s.bt);
    for (int d = 0; d < 2; d++) begin
      if (m_boot[d]) m_boot[d] = 0;
      else if (m_halted[d]) begin end
      else if (s.halt) begin m_halted[d] = 1; m_flush_left[d] = 0; end
      else if (taken) begin
        m_pc[d] = tgt;
        m_flush_left[d] = m_flen[d];
        if (m_cnt[d] < 255) m_cnt[d]++;
      end
      else if (m_flush_left[d] > 0) m_flush_left[d]--;
      else if (!s.stall) m_pc[d] = (m_pc[d] + 2) % 65536;
    end
  endtask

  task automatic check_model(input stim_t s);
    bit exp_fv;
    for (int d = 0; d < 2; d++) begin
      exp_fv = !m_boot[d] && !m_halted[d] && (m_flush_left[d] == 0) && !s.stall;
      chk($sformatf("m%0d.pc", d), 32'(pc_w[d]), 32'(m_pc[d]));
      chk($sformatf("m%0d.pcPlus", d), 32'(pcp_w[d]), 32'((m_pc[d] + 2) % 65536));
      chk($sformatf("m%0d.fetchValid", d), 32'(fv_w[d]), 32'(exp_fv));
      chk($sformatf("m%0d.flush", d), 32'(fl_w[d]), 32'(m_flush_left[d] > 0 && !m_halted[d]));
      chk($sformatf("m%0d.halted", d), 32'(hl_w[d]), 32'(m_halted[d]));
      chk($sformatf("m%0d.redirCnt", d), 32'(cnt_w[d]), 32'(m_cnt[d]));
    end
  endtask

  // Drive inputs, let them settle, compare against the model.
  task automatic apply(input stim_t s);
    stall = s.stall; brchValid = s.bv; jmpSel = s.js; brchTgt = s.bt;
    jmpValid = s.jv; jmpTgt = s.jt; haltReq = s.halt;
    #1;
    check_model(s);
  endtask

  task automatic tick(input stim_t s);
    @(posedge clk);
    model_step(s);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  stim_t idle;
  stim_t s;
  vec_t  vecs [14];

  initial begin
    idle = mk(0, 0, 0, 16'h0, 0, 16'h0, 0);
    // Directed table for the 1-bubble instance, from reset release onward.
    vecs[0]  = mv(idle, 16'h0000, 0, 0, 8'd0);
    vecs[1]  = mv(idle, 16'h0000, 1, 0, 8'd0);
    vecs[2]  = mv(idle, 16'h0002, 1, 0, 8'd0);
    vecs[3]  = mv(idle, 16'h0004, 1, 0, 8'd0);
    vecs[4]  = mv(mk(0, 1, 1, 16'h0040, 0, 16'h0, 0), 16'h0006, 1, 0, 8'd0);
    vecs[5]  = mv(idle, 16'h0040, 0, 1, 8'd1);
    vecs[6]  = mv(idle, 16'h0040, 1, 0, 8'd1);
    vecs[7]  = mv(mk(0, 1, 0, 16'h0200, 0, 16'h0, 0), 16'h0042, 1, 0, 8'd1);
    vecs[8]  = mv(idle, 16'h0044, 1, 0, 8'd1);
    vecs[9]  = mv(mk(1, 1, 1, 16'h0200, 1, 16'h0100, 0), 16'h0046, 0, 0, 8'd1);
    vecs[10] = mv(idle, 16'h0100, 0, 1, 8'd2);
    vecs[11] = mv(mk(1, 0, 0, 16'h0, 0, 16'h0, 0), 16'h0100, 0, 0, 8'd2);
    vecs[12] = mv(idle, 16'h0100, 1, 0, 8'd2);
    vecs[13] = mv(idle, 16'h0102, 1, 0, 8'd2);

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.pc", 32'(pc_w[0]), 32'h0);
    chk("reset.flush", 32'(fl_w[0]), 32'h0);
    chk("reset.fetchValid", 32'(fv_w[0]), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply(vecs[i].s);
      chk($sformatf("vec%0d.pc", i), 32'(pc_w[0]), 32'(vecs[i].pc));
      chk($sformatf("vec%0d.fetchValid", i), 32'(fv_w[0]), 32'(vecs[i].fv));
      chk($sformatf("vec%0d.flush", i), 32'(fl_w[0]), 32'(vecs[i].fl));
      chk($sformatf("vec%0d.redirCnt", i), 32'(cnt_w[0]), 32'(vecs[i].cnt));
      $display("vec %0d pc=%04h fv=%0b flush=%0b cnt=%0d", i, pc_w[0], fv_w[0], fl_w[0], cnt_w[0]);
      tick(vecs[i].s);
    end

    // Redirect during the second of three flush cycles restarts the flush.
    apply_reset();
    apply(idle); tick(idle);
    s = mk(0, 0, 0, 16'h0, 1, 16'h0080, 0);
    apply(s); tick(s);
    apply(idle); chk("refl.f1", 32'(fl_w[1]), 32'h1); tick(idle);
    s = mk(0, 0, 0, 16'h0, 1, 16'h00C0, 0);
    apply(s); chk("refl.f2.pc", 32'(pc_w[1]), 32'h0080); tick(s);
    for (int i = 0; i < 3; i++) begin
      apply(idle);
      chk($sformatf("refl.c%0d.flush", i), 32'(fl_w[1]), 32'h1);
      chk($sformatf("refl.c%0d.pc", i), 32'(pc_w[1]), 32'h00C0);
      tick(idle);
    end
    apply(idle);
    chk("refl.end.flush", 32'(fl_w[1]), 32'h0);
    chk("refl.end.fv", 32'(fv_w[1]), 32'h1);
    chk("refl.end.cnt", 32'(cnt_w[1]), 32'h2);
    $display("seq reflush pc=%04h cnt=%0d", pc_w[1], cnt_w[1]);
    tick(idle);

    // Halt inside a flush freezes the target and drops flush.
    apply_reset();
    apply(idle); tick(idle);
    s = mk(0, 0, 0, 16'h0, 1, 16'h0080, 0);
    apply(s); tick(s);
    s = mk(0, 0, 0, 16'h0, 0, 16'h0, 1);
    apply(s); chk("hflush.pre", 32'(fl_w[1]), 32'h1); tick(s);
    apply(idle);
    chk("hflush.halted", 32'(hl_w[1]), 32'h1);
    chk("hflush.flush", 32'(fl_w[1]), 32'h0);
    chk("hflush.pc", 32'(pc_w[1]), 32'h0080);
    tick(idle);
    s = mk(1, 1, 1, 16'h0300, 1, 16'h1234, 0);
    apply(s); tick(s);
    apply(idle); chk("hflush.frozen", 32'(pc_w[1]), 32'h0080);
    $display("seq halt-in-flush pc=%04h halted=%0b", pc_w[1], hl_w[1]);
    tick(idle);

    // PC wrap, halt, ignored inputs, then asynchronous reset between edges.
    apply_reset();
    apply(idle); tick(idle);
    s = mk(0, 0, 0, 16'h0, 1, 16'hFFFE, 0);
    apply(s); tick(s);
    apply(idle); tick(idle);
    apply(idle);
    chk("wrap.pc", 32'(pc_w[0]), 32'hFFFE);
    chk("wrap.pcPlus", 32'(pcp_w[0]), 32'h0000);
    tick(idle);
    apply(idle); chk("wrap.next", 32'(pc_w[0]), 32'h0000);
    s = mk(0, 0, 0, 16'h0, 0, 16'h0, 1);
    tick(idle);
    apply(s); tick(s);
    apply(idle); chk("halt.halted", 32'(hl_w[0]), 32'h1); tick(idle);
    s = mk(1, 0, 0, 16'h0, 1, 16'h4444, 0);
    apply(s); tick(s);
    apply(idle);
    chk("halt.frozen", 32'(pc_w[0]), 32'h0002);
    chk("halt.fv", 32'(fv_w[0]), 32'h0);
    $display("seq wrap/halt pc=%04h halted=%0b", pc_w[0], hl_w[0]);
    #2;
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("arst%0d.pc", d), 32'(pc_w[d]), 32'h0);
      chk($sformatf("arst%0d.halted", d), 32'(hl_w[d]), 32'h0);
      chk($sformatf("arst%0d.cnt", d), 32'(cnt_w[d]), 32'h0);
    end
    $display("seq async-reset pc=%04h halted=%0b", pc_w[0], hl_w[0]);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      if (m_halted[0] && m_halted[1] && ($urandom_range(0, 3) == 0)) apply_reset();
      s = mk(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) < 3), 1'($urandom),
             16'($urandom), ($urandom_range(0, 19) < 3), 16'($urandom),
             ($urandom_range(0, 49) == 0));
      apply(s);
      $display("rnd %0d pc=%04h/%04h fl=%0b/%0b cnt=%0d/%0d", i, pc_w[0], pc_w[1],
               fl_w[0], fl_w[1], cnt_w[0], cnt_w[1]);
      tick(s);
    end

    // Counter saturation: a redirect every cycle for 300 cycles.
    apply_reset();
    apply(idle); tick(idle);
    for (int i = 0; i < 303; i++) begin
      s = mk(1'($urandom), 0, 0, 16'h0, 1, 16'($urandom), 0);
      apply(s);
      tick(s);
      if (i == 299) begin
        apply(idle);
        chk("sat0.cnt", 32'(cnt_w[0]), 32'hFF);
        chk("sat1.cnt", 32'(cnt_w[1]), 32'hFF);
        $display("seq saturate cnt=%0d/%0d", cnt_w[0], cnt_w[1]);
      end
    end
    apply(idle);
    chk("sat.hold0", 32'(cnt_w[0]), 32'hFF);
    chk("sat.hold1", 32'(cnt_w[1]), 32'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Fetch-stage PC sequencer. Sits directly downstream of branch_conditional and consumes its jmpSel.
- Holds the architectural fetch PC and chooses the next PC from: sequential, branch target, jump target, or hold (stall/halt).
- On every redirect it drives a timed flush of younger instructions.
- Counts taken redirects for performance debug.

Parameters:
- PC_WIDTH, 16, width of PC and targets
- RESET_PC, 16'h0000, PC value loaded on reset
- INSTR_BYTES, 2, sequential PC increment
- FLUSH_CYCLES, 1, bubble cycles asserted on flush after a redirect (1..7)
- CNT_WIDTH, 8, width of redirect counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC this cycle (downstream not ready)
- brchValid  in  1  a conditional branch resolves this cycle
- jmpSel  in  1  branch condition met, from branch_conditional
- brchTgt  in  PC_WIDTH  conditional branch target
- jmpValid  in  1  unconditional jump resolves this cycle
- jmpTgt  in  PC_WIDTH  jump target
- haltReq  in  1  HALT instruction retired
- pc  out  PC_WIDTH  current fetch address
- pcPlus  out  PC_WIDTH  pc + INSTR_BYTES, modulo 2^PC_WIDTH
- fetchValid  out  1  instruction at pc is valid this cycle
- flush  out  1  kill younger in-flight instructions
- halted  out  1  sequencer stopped
- redirCnt  out  CNT_WIDTH  saturating count of taken redirects

Behaviour:
- Reset is asynchronous on rst_n low. It forces:
  - state=BOOT, pc=RESET_PC
  - fetchValid=0, flush=0, halted=0
  - redirCnt=0, internal flush counter=0
- Reset deasserting mid-operation has no memory of prior state.
- Redirect definition: redirect = jmpValid | (brchValid & jmpSel).
  - Target priority: jmpTgt beats brchTgt when both are valid.
  - brchValid with jmpSel=0 is a not-taken branch. It is treated as sequential.
- Event priority each cycle: haltReq > redirect > stall > sequential.
- States:
  - BOOT: one cycle after reset. fetchValid=0, pc held at RESET_PC. Next state is always RUN. Inputs are ignored, including haltReq.
  - RUN: fetchValid=1 unless stall=1.
    - haltReq -> HALTED, pc held.
    - redirect -> pc<=target, flush counter<=FLUSH_CYCLES, next state FLUSH.
    - stall with no redirect -> pc held.
    - otherwise pc<=pcPlus.
  - FLUSH: flush=1 and fetchValid=0 for every cycle in this state.
    - pc holds the redirect target. No increment, regardless of stall.
    - Counter decrements each cycle; at count 1 the next state is RUN.
    - New redirect in FLUSH -> pc<=new target, counter reloads to FLUSH_CYCLES, stay in FLUSH.
    - haltReq in FLUSH -> HALTED. flush deasserts next cycle.
  - HALTED: halted=1, fetchValid=0, flush=0, pc frozen. All inputs are ignored. Only reset exits this state.
- Output timing: all outputs are registered, or decoded directly from registered state.
  - Latency from redirect input to new pc on the bus is 1 cycle.
  - flush rises in that same cycle and lasts exactly FLUSH_CYCLES cycles.
- Stall never blocks a redirect. A redirect in a stalled cycle is still taken.
- Arithmetic:
  - pcPlus wraps modulo 2^PC_WIDTH, so 16'hFFFE+2=16'h0000. No overflow flag.
  - Targets are used as-is. Odd targets are not checked.
- redirCnt:
  - Increments by 1 on each accepted redirect in RUN or FLUSH.
  - Saturates at all-ones.
  - Not-taken branches, and any redirect in BOOT or HALTED, do not count.

Test Plan:
- Reset then 4 free cycles, no stall -> BOOT cycle pc=0000 fetchValid=0; then pc=0000,0002,0004 with fetchValid=1; redirCnt=0.
- At pc=0006: brchValid=1, jmpSel=1, brchTgt=0040 -> next cycle pc=0040, flush=1 for 1 cycle, fetchValid=0; then pc=0040 valid, 0042; redirCnt=1. Same stimulus with jmpSel=0 -> pc=0008, no flush, redirCnt unchanged.
- Same cycle: jmpValid=1 jmpTgt=0100, brchValid=1 jmpSel=1 brchTgt=0200, stall=1 -> pc=0100 and flush=1. Jump wins and stall is overridden.
- FLUSH_CYCLES=3: redirect to 0080, then in the second flush cycle redirect to 00C0 -> pc=00C0, flush stays high 3 more cycles, redirCnt +2. Same setup with haltReq=1 in a flush cycle -> halted=1 next cycle, flush=0, pc frozen at 0080.
- pc=FFFE free-running -> pc=0000 next. haltReq -> halted=1; later redirect/stall ignored. Assert rst_n low asynchronously between clock edges -> pc=0000, halted=0 immediately.
- Drive 300 taken redirects with CNT_WIDTH=8 -> redirCnt saturates at FF and stays at FF.
